rv32i_encoder: RTL and testbench
================================

# rv32i_encoder

Pipelined RV32I instruction encoder: the inverse of the decode stage. It accepts instruction fields (class, func3, alt bit, register indices, full-width immediate) over a valid/ready handshake, range-checks them, packs them into a legal 32-bit RV32I word, and buffers results in a 2-entry output FIFO. It feeds the debug/self-test instruction injector that drives the fetch stage, so every emitted word must decode back to the requested fields.

## Interface
- `size`, 32, instruction and immediate width; only 32 is supported.
- `clk` input 1, rising-edge clock.
- `reset` input 1, synchronous, active-high; clears FIFO, error state and counter.
- `flush` input 1, synchronous; empties FIFO and leaves `err_count` unchanged.
- `in_valid` input 1, request valid.
- `in_ready` output 1, request accepted when `in_valid & in_ready`.
- `op_sel` input 4, encoding class:
  - 0 R, 1 I-ALU, 2 LOAD, 3 JALR, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL.
  - 9–15 are illegal.
- `func3` input 3, func3 field; ignored for JALR (forced 000), LUI, AUIPC and JAL.
- `alt` input 1, sets instruction bit 30 (SUB/SRA/SRAI).
- `rd`, `rs1`, `rs2` input 5 each; an index is ignored for any class that has no such field.
- `imm` input 32, signed byte-offset or value; for LUI/AUIPC it is the full upper value.
- `out_valid` output 1, FIFO head valid.
- `out_ready` input 1, consumer pops head when `out_valid & out_ready`.
- `out_instr` output 32, FIFO head word; holds 0 when empty.
- `err_valid` output 1, one-cycle pulse for a rejected request.
- `err_count` output 8, saturating count of rejected requests.

## Operation
- **Accept rule:** `in_ready = (count < 2)`, computed from registered state only, with no combinational path from `in_valid`.
- **Legality checks.** Any failure rejects the request. A rejected request is consumed (handshake completes), is not pushed, pulses `err_valid`, and increments `err_count`, which saturates at 255.
  - I-ALU/LOAD/JALR/STORE: imm in [-2048, 2047].
  - I-ALU shifts (func3 001/101): imm in [0, 31].
  - BRANCH: imm in [-4096, 4094] and even.
  - JAL: imm in [-1048576, 1048574] and even.
  - LUI/AUIPC: imm[11:0] == 0.
  - R: alt = 1 only with func3 000 or 101.
  - I-ALU: alt = 1 only with func3 101.
  - LOAD func3 ∈ {000, 001, 010, 100, 101}.
  - STORE func3 ∈ {000, 001, 010}.
  - BRANCH func3 ∉ {010, 011}.
  - op_sel ≥ 9.
- **Packing.** Standard RV32I field placement per type.
  - Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, JALR 1100111, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111.
  - R: funct7 = {1'b0, alt, 5'b0}.
  - I-ALU shifts: bits 31:25 = {1'b0, alt, 5'b0} and bits 24:20 = imm[4:0].
  - Fields not used by a class are zero in the emitted word.
- **FIFO.**
  - 2 entries with a registered count (0–2).
  - Push and pop in the same cycle at count 1 leaves the count at 1 and updates the head correctly.
  - A pop at count 0 is ignored.
- **Flush/reset.** `flush` or `reset` in the same cycle as an accept or pop discards that accept or pop. Reset takes priority over flush.

## Timing
- Reset values:
  - `in_ready` 1, `out_valid` 0, `out_instr` 0.
  - `err_valid` 0, `err_count` 0.
  - count 0.
- Latency: a request accepted at edge N appears on `out_instr` with `out_valid` = 1 after edge N (visible in cycle N+1) when the FIFO was empty or popped at N.
- `err_valid` is high in exactly the cycle after the rejecting edge.
- Throughput: one request per cycle while `out_ready` stays high.
- `out_instr` is stable while `out_valid & ~out_ready`.
- `in_ready` is low while count = 2.

## Test plan
- R and I-ALU packing: ADD x3,x1,x2 -> 0x002081B3; ADDI x1,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00093; SRAI x4,x4,3 -> 0x40325213; each appears one cycle after accept.
- Store and branch immediate scrambling: SW x2,8(x1) -> 0x0020A423; BEQ x1,x2,-4 -> 0xFE208EE3.
- Upper and jump classes: LUI x5,0x12345000 -> 0x123452B7; JAL x1,2048 -> 0x001000EF; JALR with func3 = 111 input -> func3 field emitted as 000.
- Rejection: BRANCH imm = 3, ADDI imm = 2048, op_sel = 12 -> no push, three `err_valid` pulses, `err_count` = 3; 300 illegal requests -> `err_count` = 255.
- Backpressure: `out_ready` = 0, four back-to-back requests -> two accepted, `in_ready` = 0 from the cycle after the second accept, head stable; release `out_ready` -> words emitted in order, remaining requests then accepted.
- Flush and reset mid-stream: FIFO at count 2, assert `flush` together with a pop -> count 0, `out_valid` = 0, `err_count` unchanged; then `reset` with pending `err_count` = 5 -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/rv32i_encoder_if.sv
// Request/response bundle for the RV32I encoder: field request in,
// packed instruction words and rejection status out.
interface rv32i_encoder_if #(
  parameter int size = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op_sel;
  logic [2:0]      func3;
  logic            alt;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [size-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] out_instr;
  logic            err_valid;
  logic [7:0]      err_count;

  modport master (
    output in_valid, op_sel, func3, alt, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_instr, err_valid, err_count
  );

  modport slave (
    input  in_valid, op_sel, func3, alt, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_instr, err_valid, err_count
  );
endinterface

// File: rtl/rv32i_encoder.sv
// RV32I encoder: range-checks requested fields, packs a legal instruction
// word and queues it in a 2-entry output FIFO; rejects are counted.
module rv32i_encoder #(
  parameter int size = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  rv32i_encoder_if.slave bus
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [1:0]      count_reg;
  logic [size-1:0] head_reg;
  logic [size-1:0] tail_reg;
  logic            err_valid_reg;
  logic [7:0]      err_count_reg;

  logic            legal;
  logic [size-1:0] word;
  logic            imm12_ok;
  logic            shamt_ok;
  logic            branch_ok;
  logic            jal_ok;
  logic            upper_ok;
  logic            is_shift;
  logic            in_ready;
  logic            accept;
  logic            push;
  logic            pop;

  // Signed range tests reduce to "upper bits are a pure sign extension".
  assign imm12_ok  = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign shamt_ok  = ~(|bus.imm[31:5]);
  assign branch_ok = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
  assign jal_ok    = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
  assign upper_ok  = ~(|bus.imm[11:0]);
  assign is_shift  = (bus.func3 == 3'b001) || (bus.func3 == 3'b101);

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (bus.op_sel)
      4'd0: begin
        legal = ~bus.alt || (bus.func3 == 3'b000) || (bus.func3 == 3'b101);
        word  = {1'b0, bus.alt, 5'b0, bus.rs2, bus.rs1, bus.func3, bus.rd, OPC_R};
      end
      4'd1: begin
        legal = (is_shift ? shamt_ok : imm12_ok) && (~bus.alt || (bus.func3 == 3'b101));
        if (is_shift)
          word = {1'b0, bus.alt, 5'b0, bus.imm[4:0], bus.rs1, bus.func3, bus.rd, OPC_I_ALU};
        else
          word = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, OPC_I_ALU};
      end
      4'd2: begin
        legal = imm12_ok && (bus.func3 != 3'b011) && (bus.func3 != 3'b110)
                && (bus.func3 != 3'b111);
        word  = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, OPC_LOAD};
      end
      4'd3: begin
        legal = imm12_ok;
        word  = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_JALR};
      end
      4'd4: begin
        legal = imm12_ok && (bus.func3[2] == 1'b0) && (bus.func3 != 3'b011);
        word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3, bus.imm[4:0], OPC_STORE};
      end
      4'd5: begin
        legal = branch_ok && (bus.func3[2:1] != 2'b01);
        word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
                 bus.imm[4:1], bus.imm[11], OPC_BRANCH};
      end
      4'd6: begin
        legal = upper_ok;
        word  = {bus.imm[31:12], bus.rd, OPC_LUI};
      end
      4'd7: begin
        legal = upper_ok;
        word  = {bus.imm[31:12], bus.rd, OPC_AUIPC};
      end
      4'd8: begin
        legal = jal_ok;
        word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, OPC_JAL};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  assign in_ready = (count_reg < 2'd2);
  assign accept   = bus.in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = (count_reg != 2'd0) & bus.out_ready;

  // head_reg is the FIFO head and doubles as out_instr, so it is kept zero when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= 2'd0;
      head_reg      <= '0;
      tail_reg      <= '0;
      err_valid_reg <= 1'b0;
      err_count_reg <= 8'd0;
    end else if (flush) begin
      count_reg     <= 2'd0;
      head_reg      <= '0;
      tail_reg      <= '0;
      err_valid_reg <= 1'b0;
    end else begin
      err_valid_reg <= accept & ~legal;
      if (accept && !legal && (err_count_reg != 8'hFF))
        err_count_reg <= err_count_reg + 8'd1;

      case ({push, pop})
        2'b10: begin
          count_reg <= count_reg + 2'd1;
          if (count_reg == 2'd0)
            head_reg <= word;
          else
            tail_reg <= word;
        end
        2'b01: begin
          count_reg <= count_reg - 2'd1;
          head_reg  <= (count_reg == 2'd2) ? tail_reg : '0;
          tail_reg  <= '0;
        end
        // Push implies count < 2 and pop implies count > 0, so count is 1 here.
        2'b11: head_reg <= word;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_instr = head_reg;
  assign bus.err_valid = err_valid_reg;
  assign bus.err_count = err_count_reg;

endmodule

// File: tb/tb_rv32i_encoder.sv
// Directed, table-driven bench for rv32i_encoder with a scoreboard monitor
// on the output handshake.
module tb_rv32i_encoder;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  rv32i_encoder_if #(.size(32)) bus ();

  rv32i_encoder #(.size(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int exp_err = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [3:0] op, logic [2:0] f3, logic alt,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic ok, logic [31:0] word);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.alt = alt; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.ok = ok; v.word = word;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.op_sel = v.op;
    bus.func3  = v.f3;
    bus.alt    = v.alt;
    bus.rd     = v.rd;
    bus.rs1    = v.rs1;
    bus.rs2    = v.rs2;
    bus.imm    = v.imm;
  endtask

  // Present one request from the next falling edge until it is accepted.
  task automatic send(vec_t v);
    int waited;
    waited = 0;
    @(negedge clk);
    drive(v);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout %s: in_ready got 0 expected 1", v.name);
    end else if (v.ok) begin
      exp_q.push_back(v.word);
    end else begin
      exp_err++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: every pop that the next rising edge will perform must match in order.
  always begin
    @(negedge clk);
    #1;
    if (!reset && !flush && bus.out_valid && bus.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL pop_order: got %h expected no word", bus.out_instr);
      end else begin
        if (bus.out_instr !== exp_q[0]) begin
          failed++;
          $display("FAIL pop_order: got %h expected %h", bus.out_instr, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  vec_t illegal_v;
  vec_t legal_v;
  int budget;

  initial begin
    vecs.push_back(mk("ADD x3,x1,x2",     4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b1, 32'h002081B3));
    vecs.push_back(mk("ADDI x1,x0,-1",    4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd7, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093));
    vecs.push_back(mk("SRAI x4,x4,3",     4'd1, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'h0000_0003, 1'b1, 32'h40325213));
    vecs.push_back(mk("SUB x5,x6,x7",     4'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 32'h0000_0123, 1'b1, 32'h407302B3));
    vecs.push_back(mk("LW x5,-2048(x1)",  4'd2, 3'd2, 1'b0, 5'd5, 5'd1, 5'd9, 32'hFFFF_F800, 1'b1, 32'h8000A283));
    vecs.push_back(mk("SW x2,8(x1)",      4'd4, 3'd2, 1'b0, 5'd9, 5'd1, 5'd2, 32'h0000_0008, 1'b1, 32'h0020A423));
    vecs.push_back(mk("BEQ x1,x2,-4",     4'd5, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE208EE3));
    vecs.push_back(mk("BNE x0,x0,4094",   4'd5, 3'd1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0000_0FFE, 1'b1, 32'h7E001FE3));
    vecs.push_back(mk("LUI x5,0x12345",   4'd6, 3'd7, 1'b1, 5'd5, 5'd31, 5'd31, 32'h1234_5000, 1'b1, 32'h123452B7));
    vecs.push_back(mk("AUIPC x3,0xFFFFF", 4'd7, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'hFFFF_F000, 1'b1, 32'hFFFFF197));
    vecs.push_back(mk("JAL x1,2048",      4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h001000EF));
    vecs.push_back(mk("JAL x0,-1048576",  4'd8, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 1'b1, 32'h8000006F));
    vecs.push_back(mk("JALR f3=111",      4'd3, 3'd7, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0000_0004, 1'b1, 32'h004100E7));
    vecs.push_back(mk("BRANCH imm=3",     4'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 1'b0, 32'h0));
    vecs.push_back(mk("ADDI imm=2048",    4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0));
    vecs.push_back(mk("op_sel=12",        4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk("LOAD f3=011",      4'd2, 3'd3, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk("STORE f3=011",     4'd4, 3'd3, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk("BRANCH f3=010",    4'd5, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk("LUI imm[0]=1",     4'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5001, 1'b0, 32'h0));
    vecs.push_back(mk("JAL imm=2^20",     4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b0, 32'h0));
    vecs.push_back(mk("JAL imm odd",      4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0011, 1'b0, 32'h0));
    vecs.push_back(mk("R alt f3=001",     4'd0, 3'd1, 1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk("SLLI imm=32",      4'd1, 3'd1, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0020, 1'b0, 32'h0));
    vecs.push_back(mk("ADDI alt=1",       4'd1, 3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'h0000_0001, 1'b0, 32'h0));
    vecs.push_back(mk("BRANCH imm=4096",  4'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_1000, 1'b0, 32'h0));

    illegal_v = vecs[14];
    legal_v   = vecs[0];

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(legal_v);
    @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_instr", bus.out_instr, 32'd0);
    check("reset_err_valid", 32'(bus.err_valid), 32'd0);
    check("reset_err_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table: each word visible one cycle after accept, rejects pulse err_valid.
    foreach (vecs[k]) begin
      send(vecs[k]);
      $display("[TB] vec %0d %s: out_valid=%0d out_instr=%h err_valid=%0d",
               k, vecs[k].name, bus.out_valid, bus.out_instr, bus.err_valid);
      check({vecs[k].name, " err_valid"}, 32'(bus.err_valid), 32'(!vecs[k].ok));
      check({vecs[k].name, " out_valid"}, 32'(bus.out_valid), 32'(vecs[k].ok));
      if (vecs[k].ok)
        check({vecs[k].name, " out_instr"}, bus.out_instr, vecs[k].word);
    end
    @(posedge clk);
    #1;
    check("table_err_count", 32'(bus.err_count), 32'(exp_err));
    check("table_err_pulse_end", 32'(bus.err_valid), 32'd0);

    // Saturation: 300 back-to-back rejects.
    @(negedge clk);
    drive(illegal_v);
    bus.in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("[TB] saturate: err_count=%0d", bus.err_count);
    check("saturate_err_count", 32'(bus.err_count), 32'd255);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_clears_err_count", 32'(bus.err_count), 32'd0);
    reset = 1'b0;
    exp_q.delete();

    exp_err = 0;
    repeat (5) send(illegal_v);
    @(posedge clk);
    #1;
    $display("[TB] five rejects: err_count=%0d", bus.err_count);
    check("five_err_count", 32'(bus.err_count), 32'd5);
    check("err_valid_one_cycle", 32'(bus.err_valid), 32'd0);

    // Backpressure: two accepted, head held, then release drains in order.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[2]);
    $display("[TB] backpressure full: in_ready=%0d out_instr=%h", bus.in_ready, bus.out_instr);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_head", bus.out_instr, vecs[0].word);
    @(negedge clk);
    drive(vecs[5]);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_head_stable", bus.out_instr, vecs[0].word);
      check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(vecs[5]);
    send(vecs[6]);
    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #1;
    $display("[TB] drained: out_valid=%0d remaining=%0d", bus.out_valid, exp_q.size());
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Flush at count 2 together with a pop.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    check("flush_pre_full", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    $display("[TB] flush: out_valid=%0d in_ready=%0d err_count=%0d",
             bus.out_valid, bus.in_ready, bus.err_count);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_out_instr", bus.out_instr, 32'd0);
    check("flush_err_count", 32'(bus.err_count), 32'd5);
    @(negedge clk);
    drive(illegal_v);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush_drops_reject_count", 32'(bus.err_count), 32'd5);
    check("flush_drops_reject_pulse", 32'(bus.err_valid), 32'd0);
    @(negedge clk);
    drive(legal_v);
    @(posedge clk);
    #1;
    check("flush_drops_push", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;

    // Reset mid-stream with a pending word and err_count = 5.
    bus.out_ready = 1'b0;
    send(vecs[8]);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    check("pre_reset_err_count", 32'(bus.err_count), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    $display("[TB] reset: in_ready=%0d out_valid=%0d out_instr=%h err_count=%0d",
             bus.in_ready, bus.out_valid, bus.out_instr, bus.err_count);
    check("mid_reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_reset_out_instr", bus.out_instr, 32'd0);
    check("mid_reset_err_valid", 32'(bus.err_valid), 32'd0);
    check("mid_reset_err_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
